// File: rtl/lpt_if.sv
// Signal bundle for the lpt_controller instruction handshake and datapath controls.
// The master side issues instructions; the slave side is the controller.
interface lpt_if;
   logic       start;
   logic [2:0] op;
   logic [1:0] rd;
   logic [1:0] rm;
   logic       w;
   logic [1:0] Rn;
   logic [2:0] sr;
   logic [1:0] aluop;
   logic       lt;
   logic [2:0] tsel;
   logic [2:0] bsel;
   logic       busy;
   logic       done;
   logic       err;
   logic [7:0] icount;

   modport master (
      output start, op, rd, rm,
      input  w, Rn, sr, aluop, lt, tsel, bsel, busy, done, err, icount
   );

   modport slave (
      input  start, op, rd, rm,
      output w, Rn, sr, aluop, lt, tsel, bsel, busy, done, err, icount
   );
endinterface

// File: rtl/lpt_controller.sv
// Moore control FSM for a 4-register datapath: LOAD/MOV/XOR/AND/SHL.
// Outputs are decoded only from the registered state and the latched instruction fields.
module lpt_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] op,
   input  logic [1:0] rd,
   input  logic [1:0] rm,
   output logic       w,
   output logic [1:0] Rn,
   output logic [2:0] sr,
   output logic [1:0] aluop,
   output logic       lt,
   output logic [2:0] tsel,
   output logic [2:0] bsel,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [7:0] icount
);
   typedef enum logic [1:0] {S_IDLE, S_TMP, S_WRITE, S_DONE} state_t;

   localparam logic [2:0] OP_LOAD = 3'b000;
   localparam logic [2:0] OP_MOV  = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_AND  = 3'b011;
   localparam logic [2:0] OP_SHL  = 3'b100;

   state_t     state_q, state_d;
   logic [2:0] op_q, op_d;
   logic [1:0] rd_q, rd_d;
   logic [1:0] rm_q, rm_d;
   logic       err_q, err_d;
   logic [7:0] icount_q, icount_d;

   function automatic logic [2:0] onehot_rm(input logic [1:0] r);
      case (r)
         2'd1:    onehot_rm = 3'b001;
         2'd2:    onehot_rm = 3'b010;
         2'd3:    onehot_rm = 3'b100;
         default: onehot_rm = 3'b000;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         rd_q     <= '0;
         rm_q     <= '0;
         err_q    <= 1'b0;
         icount_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         rd_q     <= rd_d;
         rm_q     <= rm_d;
         err_q    <= err_d;
         icount_q <= icount_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      rd_d     = rd_q;
      rm_d     = rm_q;
      err_d    = err_q;
      icount_d = icount_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d  = op;
               rd_d  = rd;
               rm_d  = rm;
               err_d = 1'b0;
               case (op)
                  OP_LOAD:                        state_d = S_WRITE;
                  OP_MOV, OP_XOR, OP_AND, OP_SHL: state_d = S_TMP;
                  default: begin
                     state_d = S_DONE;
                     err_d   = 1'b1;
                  end
               endcase
            end
         end
         S_TMP:   state_d = S_WRITE;
         S_WRITE: state_d = S_DONE;
         S_DONE: begin
            state_d = S_IDLE;
            if (!err_q) icount_d = icount_q + 8'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      w      = 1'b0;
      Rn     = '0;
      sr     = '0;
      aluop  = '0;
      lt     = 1'b0;
      tsel   = '0;
      bsel   = '0;
      busy   = (state_q != S_IDLE);
      done   = 1'b0;
      err    = 1'b0;
      icount = icount_q;
      case (state_q)
         S_TMP: begin
            lt = 1'b1;
            // MOV from R1..R3 routes through the B bus; everything else stages R0
            if (op_q == OP_MOV && rm_q != 2'd0) begin
               tsel = 3'b100;
               bsel = onehot_rm(rm_q);
            end else begin
               tsel = 3'b010;
            end
         end
         S_WRITE: begin
            w  = 1'b1;
            Rn = rd_q;
            case (op_q)
               OP_LOAD: sr = 3'b001;
               OP_MOV:  sr = 3'b100;
               OP_XOR: begin
                  sr    = 3'b010;
                  aluop = 2'b00;
                  bsel  = onehot_rm(rm_q);
               end
               OP_AND: begin
                  sr    = 3'b010;
                  aluop = 2'b01;
                  bsel  = onehot_rm(rm_q);
               end
               OP_SHL: begin
                  sr    = 3'b010;
                  aluop = 2'b10;
               end
               default: sr = '0;
            endcase
         end
         S_DONE: begin
            done = 1'b1;
            err  = err_q;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_lpt_controller.sv
// Directed bench for lpt_controller: expected per-cycle output vectors are queued
// when an instruction is issued and compared one cycle at a time.
module tb_lpt_controller;
   logic clk = 1'b0;
   logic reset;

   lpt_if bus ();

   lpt_controller dut (
      .clk    (clk),
      .reset  (reset),
      .start  (bus.start),
      .op     (bus.op),
      .rd     (bus.rd),
      .rm     (bus.rm),
      .w      (bus.w),
      .Rn     (bus.Rn),
      .sr     (bus.sr),
      .aluop  (bus.aluop),
      .lt     (bus.lt),
      .tsel   (bus.tsel),
      .bsel   (bus.bsel),
      .busy   (bus.busy),
      .done   (bus.done),
      .err    (bus.err),
      .icount (bus.icount)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [25:0] e;
      string       tag;
   } exp_t;

   exp_t       q[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_icount = '0;

   // {w, Rn, sr, aluop, lt, tsel, bsel, busy, done, err, icount}
   function automatic logic [25:0] vec(input logic w_, input logic [1:0] rn_,
                                       input logic [2:0] sr_, input logic [1:0] alu_,
                                       input logic lt_, input logic [2:0] ts_,
                                       input logic [2:0] bs_, input logic busy_,
                                       input logic done_, input logic err_,
                                       input logic [7:0] ic_);
      vec = {w_, rn_, sr_, alu_, lt_, ts_, bs_, busy_, done_, err_, ic_};
   endfunction

   function automatic logic [2:0] oh(input logic [1:0] r);
      case (r)
         2'd0: oh = 3'b000;
         2'd1: oh = 3'b001;
         2'd2: oh = 3'b010;
         default: oh = 3'b100;
      endcase
   endfunction

   function automatic logic [25:0] observed();
      observed = {bus.w, bus.Rn, bus.sr, bus.aluop, bus.lt, bus.tsel, bus.bsel,
                  bus.busy, bus.done, bus.err, bus.icount};
   endfunction

   task automatic push(input logic [25:0] e, input string tag);
      exp_t x;
      x.e   = e;
      x.tag = tag;
      q.push_back(x);
   endtask

   // Queue expectations for every cycle after the accept edge, ending with the IDLE cycle.
   task automatic push_seq(input logic [2:0] o, input logic [1:0] d, input logic [1:0] m);
      logic [7:0] ic;
      ic = exp_icount;
      case (o)
         3'b000: push(vec(1, d, 3'b001, 2'b00, 0, 3'b000, 3'b000, 1, 0, 0, ic), "load_write");
         3'b001: begin
            if (m == 2'd0)
               push(vec(0, 2'd0, 3'b000, 2'b00, 1, 3'b010, 3'b000, 1, 0, 0, ic), "mov_tmp_r0");
            else
               push(vec(0, 2'd0, 3'b000, 2'b00, 1, 3'b100, oh(m), 1, 0, 0, ic), "mov_tmp_b");
            push(vec(1, d, 3'b100, 2'b00, 0, 3'b000, 3'b000, 1, 0, 0, ic), "mov_write");
         end
         3'b010: begin
            push(vec(0, 2'd0, 3'b000, 2'b00, 1, 3'b010, 3'b000, 1, 0, 0, ic), "xor_tmp");
            push(vec(1, d, 3'b010, 2'b00, 0, 3'b000, oh(m), 1, 0, 0, ic), "xor_write");
         end
         3'b011: begin
            push(vec(0, 2'd0, 3'b000, 2'b00, 1, 3'b010, 3'b000, 1, 0, 0, ic), "and_tmp");
            push(vec(1, d, 3'b010, 2'b01, 0, 3'b000, oh(m), 1, 0, 0, ic), "and_write");
         end
         3'b100: begin
            push(vec(0, 2'd0, 3'b000, 2'b00, 1, 3'b010, 3'b000, 1, 0, 0, ic), "shl_tmp");
            push(vec(1, d, 3'b010, 2'b10, 0, 3'b000, 3'b000, 1, 0, 0, ic), "shl_write");
         end
         default: ;
      endcase
      if (o > 3'b100) begin
         push(vec(0, 2'd0, 3'b000, 2'b00, 0, 3'b000, 3'b000, 1, 1, 1, ic), "illegal_done");
      end else begin
         push(vec(0, 2'd0, 3'b000, 2'b00, 0, 3'b000, 3'b000, 1, 1, 0, ic), "done");
         exp_icount = exp_icount + 8'd1;
      end
      push(vec(0, 2'd0, 3'b000, 2'b00, 0, 3'b000, 3'b000, 0, 0, 0, exp_icount), "idle_after");
   endtask

   task automatic tick();
      exp_t       x;
      logic [25:0] obs;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
         x   = q.pop_front();
         obs = observed();
         checks++;
         assert (obs === x.e)
         else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", x.tag, obs, x.e);
         end
      end
   endtask

   task automatic drain();
      int unsigned guard;
      guard = 0;
      while (q.size() > 0 && guard < 20) begin
         tick();
         guard++;
      end
      checks++;
      assert (q.size() == 0)
      else begin
         errors++;
         $error("FAIL drain_timeout: observed %0d pending expected 0", q.size());
         q.delete();
      end
   endtask

   task automatic run(input logic [2:0] o, input logic [1:0] d, input logic [1:0] m);
      push_seq(o, d, m);
      bus.start = 1'b1;
      bus.op    = o;
      bus.rd    = d;
      bus.rm    = m;
      tick();
      bus.start = 1'b0;
      drain();
   endtask

   initial begin
      reset     = 1'b1;
      bus.start = 1'b1;
      bus.op    = 3'b000;
      bus.rd    = 2'd1;
      bus.rm    = 2'd0;
      push(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0), "reset_over_start");
      tick();
      bus.start = 1'b0;
      push(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0), "reset_state");
      tick();
      reset = 1'b0;
      push(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0), "idle_after_reset");
      tick();

      run(3'b000, 2'd2, 2'd0);
      run(3'b010, 2'd3, 2'd1);
      run(3'b001, 2'd1, 2'd0);
      run(3'b001, 2'd2, 2'd3);
      run(3'b011, 2'd0, 2'd2);
      run(3'b011, 2'd1, 2'd0);
      run(3'b100, 2'd3, 2'd1);
      run(3'b110, 2'd1, 2'd2);
      run(3'b101, 2'd0, 2'd0);
      run(3'b111, 2'd3, 2'd3);

      // back-to-back: start held high across LOAD then XOR
      push_seq(3'b000, 2'd1, 2'd0);
      push_seq(3'b010, 2'd2, 2'd3);
      bus.start = 1'b1;
      bus.op    = 3'b000;
      bus.rd    = 2'd1;
      bus.rm    = 2'd0;
      tick();
      tick();
      bus.op = 3'b010;
      bus.rd = 2'd2;
      bus.rm = 2'd3;
      tick();
      tick();
      bus.start = 1'b0;
      drain();

      // reset during SHL's TMP cycle aborts with no write/done and clears icount
      push(vec(0, 2'd0, 3'b000, 2'b00, 1, 3'b010, 3'b000, 1, 0, 0, exp_icount), "shl_tmp_pre_abort");
      bus.start = 1'b1;
      bus.op    = 3'b100;
      bus.rd    = 2'd2;
      bus.rm    = 2'd1;
      tick();
      bus.start = 1'b0;
      reset     = 1'b1;
      push(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0), "abort_reset");
      tick();
      reset = 1'b0;
      exp_icount = 8'd0;
      for (int unsigned k = 0; k < 3; k++) begin
         push(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0), "abort_quiet");
         tick();
      end
      run(3'b000, 2'd3, 2'd0);

      // icount wrap with start pulses while busy
      reset = 1'b1;
      push(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0), "wrap_reset");
      tick();
      reset      = 1'b0;
      exp_icount = 8'd0;
      for (int unsigned i = 0; i < 256; i++) begin
         push_seq(3'b000, 2'(i), 2'd0);
         bus.start = 1'b1;
         bus.op    = 3'b000;
         bus.rd    = 2'(i);
         bus.rm    = 2'd0;
         tick();
         bus.op = 3'b111;
         bus.rd = ~2'(i);
         tick();
         bus.start = 1'b0;
         drain();
      end
      checks++;
      assert (bus.icount === 8'd0)
      else begin
         errors++;
         $error("FAIL icount_wrap: observed %0d expected 0", bus.icount);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
